run_ctrl: RTL

- Run-control sequencer for the processor core. It holds the core in reset, runs it freely, single-steps it, or freezes it.
- Freezes happen on a halt instruction, on an operator stop request, or on a PC breakpoint match.
- Sits at the top level between the board buttons/switches and the core. It replaces the ad-hoc halting latch.
- Provides a clock-enable, a core reset, halt status and an executed-cycle counter for the LED display.

---
 rtl/run_ctrl.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/run_ctrl.sv
// Run-control sequencer: reset / run / single-step / halt the core.
// Define RUN_CTRL_CYCLE_SAT_EN to make the cycle counter saturate.
module run_ctrl #(
  parameter int PC_W  = 16,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run_btn,
  input  logic             step_btn,
  input  logic             stop_btn,
  input  logic             clr_btn,
  input  logic             is_halt,
  input  logic [PC_W-1:0]  pc,
  input  logic             brk_en,
  input  logic [PC_W-1:0]  brk_adr,
  output logic             core_reset,
  output logic             core_en,
  output logic             halting,
  output logic [1:0]       state,
  output logic [1:0]       halt_cause,
  output logic [CNT_W-1:0] cycles
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_STEP = 2'd2;
  localparam logic [1:0] S_HALT = 2'd3;

  localparam logic [1:0] C_NONE = 2'd0;
  localparam logic [1:0] C_INSN = 2'd1;
  localparam logic [1:0] C_USER = 2'd2;
  localparam logic [1:0] C_BRK  = 2'd3;

  logic [3:0]       r_s1, r_s2, r_s3;
  logic [3:0]       w_btn, w_edge;
  logic             w_run, w_step, w_stop, w_clr;
  logic [1:0]       r_state, w_nstate;
  logic [1:0]       r_cause, w_ncause;
  logic             r_skip;
  logic             w_bp;
  logic [CNT_W-1:0] r_cnt, w_cnt_inc;

  assign w_btn  = {clr_btn, stop_btn, step_btn, run_btn};
  assign w_edge = r_s2 & ~r_s3;
  assign w_run  = w_edge[0];
  assign w_step = w_edge[1];
  assign w_stop = w_edge[2];
  assign w_clr  = w_edge[3];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1 <= '0;
      r_s2 <= '0;
      r_s3 <= '0;
    end else begin
      r_s1 <= w_btn;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  // skip suppresses the breakpoint on the first cycle after entering RUN
  assign w_bp = (r_state == S_RUN) & brk_en
              & (pc == brk_adr) & ~r_skip;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cause <= C_NONE;
      r_skip  <= 1'b0;
    end else begin
      r_state <= w_nstate;
      r_cause <= w_ncause;
      r_skip  <= (w_nstate == S_RUN)
               && (r_state != S_RUN);
    end
  end

  always_comb begin
    w_nstate = r_state;
    w_ncause = r_cause;
    if (w_clr) begin
      w_nstate = S_IDLE;
      w_ncause = C_NONE;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (!w_stop && w_run) begin
            w_nstate = S_RUN;
            w_ncause = C_NONE;
          end else if (!w_stop && w_step) begin
            w_nstate = S_STEP;
            w_ncause = C_NONE;
          end
        end
        S_RUN: begin
          if (w_bp) begin
            w_nstate = S_HALT;
            w_ncause = C_BRK;
          end else if (w_stop) begin
            w_nstate = S_HALT;
            w_ncause = C_USER;
          end else if (is_halt) begin
            w_nstate = S_HALT;
            w_ncause = C_INSN;
          end
        end
        S_STEP: begin
          w_nstate = S_HALT;
          w_ncause = is_halt ? C_INSN : C_USER;
        end
        S_HALT: begin
          // a halt instruction can only be left through clr
          if (r_cause != C_INSN && !w_stop) begin
            if (w_run) begin
              w_nstate = S_RUN;
              w_ncause = C_NONE;
            end else if (w_step) begin
              w_nstate = S_STEP;
              w_ncause = C_NONE;
            end
          end
        end
      endcase
    end
  end

  always_comb begin
    core_reset = (r_state == S_IDLE);
    halting    = (r_state == S_HALT);
    state      = r_state;
    halt_cause = r_cause;
    cycles     = r_cnt;
    unique case (r_state)
      S_RUN:   core_en = ~w_bp & ~w_stop & ~w_clr;
      S_STEP:  core_en = ~w_clr;
      default: core_en = 1'b0;
    endcase
  end

`ifdef RUN_CTRL_CYCLE_SAT_EN
  assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + CNT_W'(1);
`else
  assign w_cnt_inc = r_cnt + CNT_W'(1);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_cnt <= '0;
    else if (w_clr)
      r_cnt <= '0;
    else if (core_en)
      r_cnt <= w_cnt_inc;
  end

endmodule
